// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared 1-bit full adder walks WIDTH-bit
// operands LSB first, one bit per clock, and reports result, carry-out and overflow.

module Adder1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);
  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic fa_r;
  logic fa_co;

  Adder1b u_fa (
    .a  (op_a_q[0]),
    .b  (op_b_q[0]),
    .ci (carry_q),
    .r  (fa_r),
    .co (fa_co)
  );

  always_comb begin
    // NOTE: every *_d starts from its hold value so no path leaves it unassigned (no latches).
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          op_a_d   = a;
          op_b_d   = sub ? ~b : b;
          carry_d  = sub;
          cnt_d    = '0;
          result_d = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d = {fa_r, result_q[WIDTH-1:1]};
        op_a_d   = {1'b0, op_a_q[WIDTH-1:1]};
        op_b_d   = {1'b0, op_b_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d   = carry_q ^ fa_co;
          cout_d  = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit and a 16-bit instance share clock and reset.

module tb_serial_add_ctrl;

  logic clk;
  logic rst;

  logic        start8, sub8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, result8;
  logic        start16, sub16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, result16;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8), .overflow(ovf8)
  );

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16), .cout(cout16), .overflow(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Observation mux: the instance under test is picked by sel16.
  logic        sel16;
  logic        o_busy, o_done, o_cout, o_ovf;
  logic [15:0] o_result;
  always_comb begin
    o_busy   = sel16 ? busy16   : busy8;
    o_done   = sel16 ? done16   : done8;
    o_cout   = sel16 ? cout16   : cout8;
    o_ovf    = sel16 ? ovf16    : ovf8;
    o_result = sel16 ? result16 : {8'h00, result8};
  end

  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic s);
    exp_t        e;
    logic [15:0] m, aa, bv;
    logic [16:0] sum;
    m     = (w == 16) ? 16'hFFFF : 16'h00FF;
    aa    = a & m;
    bv    = (s ? ~b : b) & m;
    sum   = {1'b0, aa} + {1'b0, bv} + {16'h0, s};
    e.res = sum[15:0] & m;
    e.c   = sum[w];
    e.o   = (aa[w-1] == bv[w-1]) && (e.res[w-1] != aa[w-1]);
    return e;
  endfunction

  // Issues one operation, pushes its expectation and waits (bounded) for done.
  task automatic issue_op(input logic w16, input logic [15:0] a, input logic [15:0] b,
                          input logic s, output int lat, output int bcyc, output logic to,
                          output logic [15:0] res, output logic c, output logic o);
    sel16 = w16;
    @(negedge clk);
    if (w16) begin
      start16 = 1'b1; a16 = a; b16 = b; sub16 = s;
    end else begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sub8 = s;
    end
    sb.push_back(model(w16 ? 16 : 8, a, b, s));
    @(posedge clk);
    #1;
    start8  = 1'b0; start16 = 1'b0;
    a8  = 8'($urandom);  b8  = 8'($urandom);  sub8  = ~sub8;
    a16 = 16'($urandom); b16 = 16'($urandom); sub16 = ~sub16;
    lat = 0; bcyc = 0; to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      lat++;
      if (o_done) begin
        to = 1'b0;
        break;
      end
      if (o_busy) bcyc++;
    end
    res = o_result; c = o_cout; o = o_ovf;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, result8, cout8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_dut8: got %b expected all zero", {busy8, done8, result8, cout8, ovf8});
    end
    n_checks++;
    if ({busy16, done16, result16, cout16, ovf16} !== 20'h00000) begin
      n_fail++;
      $display("FAIL reset_dut16: got %b expected all zero",
               {busy16, done16, result16, cout16, ovf16});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy8, done8, busy16, done16} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle: busy/done got %b expected 0000", {busy8, done8, busy16, done16});
    end
  endtask

  // Runs a table of 8-bit operations and checks latency, busy span and outputs.
  task automatic run_table8(input string name, input logic s, input logic [7:0] ta[3],
                            input logic [7:0] tb[3]);
    int lat, bcyc;
    logic to, c, o;
    logic [15:0] res;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue_op(1'b0, {8'h00, ta[i]}, {8'h00, tb[i]}, s, lat, bcyc, to, res, c, o);
      e = sb.pop_front();
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL %s_timeout[%0d]: no done within bound", name, i);
      end
      n_checks++;
      if (lat != 9 || bcyc != 8) begin
        n_fail++;
        $display("FAIL %s_timing[%0d]: latency %0d busy %0d expected 9 and 8", name, i, lat, bcyc);
      end
      n_checks++;
      if (res !== e.res || c !== e.c || o !== e.o) begin
        n_fail++;
        $display("FAIL %s_result[%0d]: got %h c%b v%b expected %h c%b v%b",
                 name, i, res, c, o, e.res, e.c, e.o);
      end
    end
  endtask

  task automatic test_add8;
    logic [7:0] ta[3] = '{8'h03, 8'hFF, 8'h7F};
    logic [7:0] tb[3] = '{8'h05, 8'h01, 8'h01};
    run_table8("add8", 1'b0, ta, tb);
  endtask

  task automatic test_sub8;
    logic [7:0] ta[3] = '{8'h05, 8'h03, 8'h80};
    logic [7:0] tb[3] = '{8'h03, 8'h05, 8'h01};
    run_table8("sub8", 1'b1, ta, tb);
  endtask

  task automatic test_reset_mid_run;
    int lat, bcyc, seen_done;
    logic to, c, o;
    logic [15:0] res;
    exp_t e;
    sel16 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy8, done8} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_busy: got busy %b done %b expected 0 0", busy8, done8);
    end
    n_checks++;
    if ({result8, cout8, ovf8} !== 10'h000) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h c%b v%b expected 00 c0 v0", result8, cout8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) seen_done++;
    end
    n_checks++;
    if (seen_done != 0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got %0d active cycles expected 0", seen_done);
    end
    issue_op(1'b0, 16'h0010, 16'h0020, 1'b0, lat, bcyc, to, res, c, o);
    e = sb.pop_front();
    n_checks++;
    if (to || res !== e.res || c !== e.c || o !== e.o) begin
      n_fail++;
      $display("FAIL midrst_recover: got %h c%b v%b timeout %b expected %h c%b v%b",
               res, c, o, to, e.res, e.c, e.o);
    end
  endtask

  task automatic test_back_to_back;
    int last_acc, n_acc, n_done;
    logic bb, prev_done;
    logic [15:0] ta, tb;
    logic ts;
    exp_t e;
    sel16 = 1'b0;
    last_acc = -1; n_acc = 0; n_done = 0; prev_done = 1'b0;
    for (int i = 0; i < 90; i++) begin
      @(negedge clk);
      if (o_done) begin
        n_done++;
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL b2b_pulse: done high on consecutive cycles");
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected_done: got done expected none");
        end else begin
          e = sb.pop_front();
          if (o_result !== e.res || o_cout !== e.c || o_ovf !== e.o) begin
            n_fail++;
            $display("FAIL b2b_result: got %h c%b v%b expected %h c%b v%b",
                     o_result, o_cout, o_ovf, e.res, e.c, e.o);
          end
        end
      end
      prev_done = o_done;
      bb = o_busy;
      ta = 16'($urandom); tb = 16'($urandom); ts = 1'($urandom_range(0, 1));
      start8 = (i < 64); a8 = ta[7:0]; b8 = tb[7:0]; sub8 = ts;
      @(posedge clk);
      #1;
      if (!bb && o_busy) begin
        sb.push_back(model(8, ta, tb, ts));
        if (last_acc >= 0) begin
          n_checks++;
          if (i - last_acc != 10) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles between accepts expected 10", i - last_acc);
          end
        end
        last_acc = i;
        n_acc++;
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (sb.size() != 0 || n_acc < 6 || n_done != n_acc) begin
      n_fail++;
      $display("FAIL b2b_count: accepts %0d dones %0d pending %0d expected >=6 equal 0",
               n_acc, n_done, sb.size());
    end
  endtask

  task automatic test_random16;
    int lat, bcyc, bad_timing, bad_value, bad_hold;
    logic to, c, o;
    logic [15:0] res, ta, tb;
    exp_t e;
    bad_timing = 0; bad_value = 0; bad_hold = 0;
    for (int i = 0; i < 1000; i++) begin
      ta = 16'($urandom); tb = 16'($urandom);
      issue_op(1'b1, ta, tb, 1'($urandom_range(0, 1)), lat, bcyc, to, res, c, o);
      e = sb.pop_front();
      n_checks++;
      if (to || lat != 17 || bcyc != 16) begin
        n_fail++; bad_timing++;
        if (bad_timing < 5)
          $display("FAIL rand16_timing[%0d]: latency %0d busy %0d timeout %b expected 17 16 0",
                   i, lat, bcyc, to);
      end
      n_checks++;
      if (res !== e.res || c !== e.c || o !== e.o) begin
        n_fail++; bad_value++;
        if (bad_value < 5)
          $display("FAIL rand16_result[%0d]: got %h c%b v%b expected %h c%b v%b",
                   i, res, c, o, e.res, e.c, e.o);
      end
      @(negedge clk);
      n_checks++;
      if (done16 !== 1'b0 || result16 !== res || cout16 !== c || ovf16 !== o) begin
        n_fail++; bad_hold++;
        if (bad_hold < 5)
          $display("FAIL rand16_hold[%0d]: done %b result %h expected done 0 result %h",
                   i, done16, result16, res);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sel16 = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_add8();
    test_sub8();
    test_reset_mid_run();
    test_back_to_back();
    test_random16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single instance of the team's 1-bit full-adder cell (`Adder1b`) over WIDTH-bit operands, LSB first, one bit per clock. It captures operands on a start handshake, shifts them through the shared adder while registering the carry between cycles, and presents the WIDTH-bit result with carry-out and signed-overflow flags. It is the area-minimal arithmetic path for control and bookkeeping logic where throughput is not critical.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..64.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous and active-high; one clock, no other reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result/flags valid.
- result  out  WIDTH  sum/difference, held until next accepted start.
- cout  out  1  final carry; for sub, 1 = no borrow (a >= b unsigned).
- overflow  out  1  two's-complement overflow of the operation.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy=0, done=0, result=0, cout=0, overflow=0; operand shift registers, carry register and bit counter cleared.
- IDLE: start=1 → load opA=a, opB = sub ? ~b : b, carry=sub, counter=0, clear result register; go RUN. start=0 → stay.
- RUN, each cycle: adder inputs a=opA[0], b=opB[0], ci=carry. On the edge:
  - result shifts right, adder r enters result[WIDTH-1].
  - opA and opB shift right (zero fill).
  - carry ← adder co.
  - counter increments.
  - When counter = WIDTH-1 (last bit), also capture ovf = carry_in_to_MSB XOR adder co, and cout ← co. Go DONE.
- DONE: done=1 for exactly one cycle; then go IDLE unconditionally.
- start is ignored in RUN and DONE (no queueing). The requester must hold start until it sees busy. The requester may then drop start.
- sub, a and b are don't-care outside the IDLE sampling edge. Operands are fully registered, so changes during RUN have no effect.
- result, cout and overflow change only during RUN. They are stable from the DONE cycle until the cycle after the next accepted start.
- Arithmetic: result = (a + (sub ? ~b+1 : b)) mod 2^WIDTH. cout is bit WIDTH of a + (sub ? ~b : b) + sub.
- Exactly one full-adder instance. No `+` operator on WIDTH-bit vectors in the datapath. Counter width is $clog2(WIDTH).
- rst asserted at any time, including mid-RUN: immediate return to IDLE with all reset values. The in-flight operation is abandoned and no done pulse is produced.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 from E0 to E_WIDTH.
- Bit i is processed on edge E(i+1); the last bit is on E_WIDTH.
- done=1 in the cycle after E_WIDTH, busy=0 in that cycle. Latency from start sample to done: WIDTH+1 cycles.
- The earliest next accepted start is on the edge after done, back in IDLE. Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=8, a=0x03, b=0x05, sub=0 → done exactly 9 cycles after start edge; result=0x08, cout=0, overflow=0; busy high for 8 cycles.
- WIDTH=8, a=0xFF, b=0x01, sub=0 → result=0x00, cout=1, overflow=0. Then a=0x7F, b=0x01 → result=0x80, cout=0, overflow=1.
- WIDTH=8, sub=1: a=0x05, b=0x03 → result=0x02, cout=1. Then a=0x03, b=0x05 → result=0xFE, cout=0. Then a=0x80, b=0x01 → result=0x7F, overflow=1.
- Start held high continuously with changing a/b during RUN → only one operation per WIDTH+2 cycles. Each result matches the operands present at the accepting edge.
- Assert rst asynchronously 3 cycles into RUN → outputs immediately 0, state IDLE, no done pulse. Then a new start with a=0x10, b=0x20 → result=0x30.
- WIDTH=16 randomized: 1000 operations with random a, b, sub compared against a reference model for result, cout and overflow. The bench also checks that done is a single-cycle pulse and that result is stable between done pulses.
